// File: rtl/seg_pkg.sv
// seg_pkg: shared types, glyph table and parameter checks for the scanned
// seven-segment display driver.
`default_nettype none

package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns, indexed by nibble value.
    localparam seg_t GLYPH_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic bit seg_params_ok(input int nd, input int rd, input int bc);
        return (nd >= 1) && (nd <= 16) && (rd >= 2) && (bc >= 0) && (bc < rd);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational hex nibble to active-low segment pattern.
`default_nettype none

module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       glyph
);

    // Equality search instead of a direct array index so that an unknown
    // nibble falls through to a blank glyph in simulation.
    always_comb begin
        glyph = SEG_BLANK;
        for (int i = 0; i < 16; i++) begin
            if (nibble == 4'(i)) glyph = GLYPH_TABLE[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit common-anode seven-segment driver with
// per-frame input snapshot. Define SEG_LZ_BLANK_EN for leading-zero blanking.
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PH_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    generate
        if (!seg_params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_param_err
            $error("seg_scan_driver: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
        end
    endgenerate

    logic                  started_q, started_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  load;
    logic [DW-1:0]         dig_load;
    logic [NUM_DIGITS-1:0] en_load;
    logic                  blank_ph;
    logic [3:0]            cur_nibble;
    seg_t                  cur_glyph;

    // The first edge after reset is edge 0: it snapshots inputs and starts
    // slot 0 at phase 0 rather than advancing the cleared counters.
    always_comb begin
        started_d = 1'b1;
        phase_d   = phase_q;
        idx_d     = idx_q;
        load      = 1'b0;
        if (!started_q) begin
            phase_d = '0;
            idx_d   = '0;
            load    = 1'b1;
        end else begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                phase_d = phase_q + PW'(1);
            end
            load = (phase_d == '0) && (idx_d == '0);
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] keep;
    logic                  live;

    // keep[i] is set when some enabled non-zero digit sits at index >= i.
    // With digits enabled but all zero, digit 0 alone shows "0"; with no
    // digit enabled the display stays dark.
    always_comb begin
        live     = 1'b0;
        keep     = '0;
        dig_load = digits;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            live    = live | (digit_en[i] & (digits[4*i +: 4] != 4'h0));
            keep[i] = live;
        end
        en_load = digit_en & keep;
        if (!live && (|digit_en)) begin
            en_load       = NUM_DIGITS'(1);
            dig_load[3:0] = 4'h0;
        end
    end
`else
    assign dig_load = digits;
    assign en_load  = digit_en;
`endif

    always_comb begin
        sh_dig_d = sh_dig_q;
        sh_en_d  = sh_en_q;
        sh_dp_d  = sh_dp_q;
        if (load) begin
            sh_dig_d = dig_load;
            sh_en_d  = en_load;
            sh_dp_d  = dp_in;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_ph = 1'b0;
        end else begin : g_blank
            assign blank_ph = (phase_d < PW'(BLANK_CYCLES));
        end
    endgenerate

    // Outputs are decoded from the next-state values so they line up with
    // the phase and index of the same edge.
    assign cur_nibble = sh_dig_d[int'(idx_d)*4 +: 4];

    seg_glyph_rom u_glyph_rom (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    always_comb begin
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_tick_d = load;
        if (!blank_ph && sh_en_d[idx_d]) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
            seg_d = cur_glyph;
            dp_d  = ~sh_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q    <= 1'b0;
            phase_q      <= '0;
            idx_q        <= '0;
            sh_dig_q     <= '0;
            sh_en_q      <= '0;
            sh_dp_q      <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            started_q    <= started_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            sh_dig_q     <= sh_dig_d;
            sh_en_q      <= sh_en_d;
            sh_dp_q      <= sh_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with
// NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
`default_nettype none

module tb_seg_scan_driver;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] Gb = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001;
    localparam logic [6:0] Gd = 7'b1000010;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    event mon_ev;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   kc     = -1;

    task automatic push(input string name, input logic [6:0] s, input logic d,
                        input logic [3:0] a, input logic t);
        exp_t e;
        e.name = name; e.seg = s; e.dp = d; e.an = a; e.tick = t;
        exp_q.push_back(e);
    endtask

    // One 8-cycle slot: two blank cycles, then six driven cycles.
    task automatic push_slot(input string name, input logic [3:0] a,
                             input logic [6:0] s, input logic d, input logic t);
        push({name, "_blank"}, BL, 1'b1, 4'hF, t);
        push({name, "_blank"}, BL, 1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) push({name, "_drive"}, s, d, a, 1'b0);
    endtask

    task automatic push_dark(input string name, input logic t);
        push_slot(name, 4'hF, BL, 1'b1, t);
    endtask

    task automatic push_frame_1234(input string name);
        push_slot({name, "_d0"}, 4'b1110, G4, 1'b1, 1'b1);
        push_slot({name, "_d1"}, 4'b1101, G3, 1'b1, 1'b0);
        push_slot({name, "_d2"}, 4'b1011, G2, 1'b1, 1'b0);
        push_slot({name, "_d3"}, 4'b0111, G1, 1'b1, 1'b0);
    endtask

    task automatic to_edge(input int k);
        while (kc < k) begin
            @(posedge clk);
            kc++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        kc    = -1;
    endtask

    always begin
        exp_t e;
        @(negedge clk or mon_ev);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({seg, dp, an, frame_tick} !== {e.seg, e.dp, e.an, e.tick}) begin
                n_fail++;
                $display("FAIL %s @%0t: got seg=%b dp=%b an=%b tick=%b, want seg=%b dp=%b an=%b tick=%b",
                         e.name, $time, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        digits   = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        #1;
        rst_n = 1'b0;
        repeat (5) push("reset_hold", BL, 1'b1, 4'hF, 1'b0);
        repeat (4) @(negedge clk);
        release_reset();

        push_frame_1234("f0");
        push_slot("f1_d0", 4'b1110, Gd, 1'b1, 1'b1);
        push_slot("f1_d1", 4'b1101, GC, 1'b1, 1'b0);
        push_slot("f1_d2", 4'b1011, Gb, 1'b1, 1'b0);
        push_slot("f1_d3", 4'b0111, GA, 1'b1, 1'b0);
        push_slot("f2_d0", 4'b1110, Gd, 1'b0, 1'b1);
        push_dark("f2_d1", 1'b0);
        push_slot("f2_d2", 4'b1011, Gb, 1'b1, 1'b0);
        push_dark("f2_d3", 1'b0);
        push_slot("f3_d0", 4'b1110, G4, 1'b1, 1'b1);
        push_slot("f3_d1", 4'b1101, G3, 1'b1, 1'b0);
        push("f3_d2_blank", BL, 1'b1, 4'hF, 1'b0);
        push("f3_d2_blank", BL, 1'b1, 4'hF, 1'b0);
        push("f3_d2_drive", G2, 1'b1, 4'b1011, 1'b0);

        to_edge(12);
        #1 digits = 16'hABCD;
        to_edge(33);
        #1 begin digit_en = 4'b0101; dp_in = 4'b0001; end
        to_edge(70);
        #1 begin digits = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; end

        // Asynchronous reset in the middle of a drive phase.
        to_edge(115);
        #2;
        rst_n = 1'b0;
        push("async_reset", BL, 1'b1, 4'hF, 1'b0);
        #1 ->mon_ev;
        repeat (4) push("reset_hold2", BL, 1'b1, 4'hF, 1'b0);
        repeat (3) @(negedge clk);
        release_reset();

        push_frame_1234("rr_f0");
`ifdef SEG_LZ_BLANK_EN
        push_slot("lz40_d0", 4'b1110, G0, 1'b1, 1'b1);
        push_slot("lz40_d1", 4'b1101, G4, 1'b1, 1'b0);
        push_dark("lz40_d2", 1'b0);
        push_dark("lz40_d3", 1'b0);
        push_slot("lz00_d0", 4'b1110, G0, 1'b1, 1'b1);
        push_dark("lz00_d1", 1'b0);
        push_dark("lz00_d2", 1'b0);
        push_dark("lz00_d3", 1'b0);
        to_edge(12);
        #1 digits = 16'h0040;
        to_edge(40);
        #1 digits = 16'h0000;
`endif

        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
